// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/forward controls for IF/ID and ID/EX,
// plus a one-entry mul/div scoreboard and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic             MdD,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic             LoadE,
    input  logic             MdStartE,
    input  logic             PCSrcE,
    input  logic [4:0]       RdM,
    input  logic             RegWriteM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteW,
    input  logic             MdDone,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MdBusy,
    output logic [CNT_W-1:0] StallCnt
);

    logic       PendV;
    logic [4:0] PendRd;
    logic       lwStall;
    logic       mdBlk;
    logic       mdStruct;
    logic       hz;
    logic       pendLive;

    always_comb begin
        ForwardAE = 2'b00;
        if (RegWriteM && RdM != 5'd0 && RdM == Rs1E)
            ForwardAE = 2'b10;
        else if (RegWriteW && RdW != 5'd0 && RdW == Rs1E)
            ForwardAE = 2'b01;
    end

    always_comb begin
        ForwardBE = 2'b00;
        if (RegWriteM && RdM != 5'd0 && RdM == Rs2E)
            ForwardBE = 2'b10;
        else if (RegWriteW && RdW != 5'd0 && RdW == Rs2E)
            ForwardBE = 2'b01;
    end

    // A completing op releases ID in the same cycle via the RF write-first bypass.
    assign pendLive = PendV && !MdDone;

    assign lwStall  = LoadE && RdE != 5'd0 &&
                      (RdE == Rs1D || RdE == Rs2D);
    assign mdBlk    = pendLive && PendRd != 5'd0 &&
                      (PendRd == Rs1D || PendRd == Rs2D);
    assign mdStruct = MdD && (MdStartE || pendLive);
    assign hz       = lwStall || mdBlk || mdStruct;

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else begin
            StallF = hz;
            StallD = hz;
            FlushE = hz;
        end
    end

    assign MdBusy = PendV;

    // The op launching in EX is older than any branch, so flushes never cancel it.
    always_ff @(posedge clk) begin
        if (reset) begin
            PendV  <= 1'b0;
            PendRd <= 5'd0;
        end else if (MdStartE && RdE != 5'd0) begin
            PendV  <= 1'b1;
            PendRd <= RdE;
        end else if (MdDone) begin
            PendV  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            StallCnt <= '0;
        else if (StallD && StallCnt != {CNT_W{1'b1}})
            StallCnt <= StallCnt + 1'b1;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios then random traffic,
// all checked against a rule-level reference model.
module tb_hazard_ctrl;

    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic          MdD, LoadE, MdStartE, PCSrcE;
    logic          RegWriteM, RegWriteW, MdDone;
    logic          StallF, StallD, FlushD, FlushE, MdBusy;
    logic [1:0]    ForwardAE, ForwardBE;
    logic [CW-1:0] StallCnt;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    bit       mV;
    bit [4:0] mRd;
    int       mCnt;
    bit       eStallD;

    hazard_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .MdD(MdD),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .LoadE(LoadE), .MdStartE(MdStartE), .PCSrcE(PCSrcE),
        .RdM(RdM), .RegWriteM(RegWriteM),
        .RdW(RdW), .RegWriteW(RegWriteW),
        .MdDone(MdDone),
        .StallF(StallF), .StallD(StallD),
        .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MdBusy(MdBusy), .StallCnt(StallCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2;
        if (RegWriteW && RdW != 0 && RdW == rs) return 1;
        return 0;
    endfunction

    task automatic idle();
        reset = 0; Rs1D = 0; Rs2D = 0; MdD = 0;
        Rs1E = 0; Rs2E = 0; RdE = 0; LoadE = 0;
        MdStartE = 0; PCSrcE = 0; RdM = 0; RegWriteM = 0;
        RdW = 0; RegWriteW = 0; MdDone = 0;
    endtask

    // compare every output with the model for the current inputs
    task automatic check_all();
        bit lw, blk, st, hz;
        #1;
        lw  = LoadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        blk = mV && !MdDone && mRd != 0 && (mRd == Rs1D || mRd == Rs2D);
        st  = MdD && (MdStartE || (mV && !MdDone));
        hz  = lw || blk || st;
        eStallD = !PCSrcE && hz;
        chk("StallF", 32'(StallF), 32'(!PCSrcE && hz));
        chk("StallD", 32'(StallD), 32'(eStallD));
        chk("FlushD", 32'(FlushD), 32'(PCSrcE));
        chk("FlushE", 32'(FlushE), 32'(PCSrcE || hz));
        chk("ForwardAE", 32'(ForwardAE), 32'(fwd(Rs1E)));
        chk("ForwardBE", 32'(ForwardBE), 32'(fwd(Rs2E)));
        chk("MdBusy", 32'(MdBusy), 32'(mV));
        chk("StallCnt", 32'(StallCnt), 32'(mCnt));
    endtask

    task automatic tick();
        check_all();
        @(posedge clk);
        if (reset) begin
            mV = 0; mRd = 0; mCnt = 0;
        end else begin
            if (MdStartE && RdE != 0) begin
                mV = 1; mRd = RdE;
            end else if (MdDone) begin
                mV = 0;
            end
            if (eStallD && mCnt < CMAX) mCnt++;
        end
        #1;
    endtask

    task automatic do_reset();
        idle(); reset = 1; tick(); reset = 0;
    endtask

    initial begin
        mV = 0; mRd = 0; mCnt = 0; eStallD = 0;
        idle(); reset = 1;
        @(posedge clk); #1;
        reset = 0;
        check_all();
        chk("rst_allzero", {StallF, StallD, FlushD, FlushE, ForwardAE,
            ForwardBE, MdBusy, 28'(StallCnt)}, 32'd0);

        // load-use
        LoadE = 1; RdE = 5; Rs1D = 5; tick();
        idle(); tick();
        chk("lu_cnt", 32'(StallCnt), 32'd1);
        LoadE = 1; RdE = 0; Rs1D = 0; tick();
        chk("lu_x0_stall", 32'(StallD), 32'd0);
        idle();

        // forwarding priority
        RegWriteM = 1; RegWriteW = 1; RdM = 7; RdW = 7; Rs1E = 7; tick();
        RegWriteM = 0; tick();
        chk("fwd_wb", 32'(ForwardAE), 32'd1);
        Rs1E = 0; tick();
        chk("fwd_x0", 32'(ForwardAE), 32'd0);
        idle();

        // md dependency: three stalled cycles, then done releases
        do_reset();
        MdStartE = 1; RdE = 9; tick();
        idle(); Rs2D = 9;
        repeat (3) tick();
        MdDone = 1; tick();
        chk("md_done_nostall", 32'(StallD), 32'd0);
        idle(); tick();
        chk("md_busy_clear", 32'(MdBusy), 32'd0);
        chk("md_cnt3", 32'(StallCnt), 32'd3);

        // structural, and simultaneous done + new launch
        MdStartE = 1; RdE = 4; tick();
        idle(); MdD = 1; tick();
        chk("struct_stall", 32'(StallD), 32'd1);
        idle(); MdDone = 1; MdStartE = 1; RdE = 12; tick();
        idle(); Rs1D = 12; tick();
        chk("swap_busy", 32'(MdBusy), 32'd1);
        chk("swap_rd12", 32'(StallD), 32'd1);
        // launch to x0 with done clears entry
        MdStartE = 1; RdE = 0; MdDone = 1; Rs1D = 0; tick();
        idle(); tick();
        chk("x0_done_clear", 32'(MdBusy), 32'd0);

        // branch priority over load-use
        do_reset();
        LoadE = 1; RdE = 3; Rs2D = 3; PCSrcE = 1; tick();
        chk("br_cnt", 32'(StallCnt), 32'd0);
        idle();

        // reset mid-op, then stray done
        MdStartE = 1; RdE = 6; tick();
        idle(); LoadE = 1; RdE = 2; Rs1D = 2; tick();
        idle(); reset = 1; tick(); reset = 0;
        chk("rst_busy", 32'(MdBusy), 32'd0);
        chk("rst_cnt", 32'(StallCnt), 32'd0);
        MdDone = 1; Rs1D = 6; tick();
        idle(); tick();
        chk("stray_done", 32'(MdBusy), 32'd0);

        // saturation
        LoadE = 1; RdE = 8; Rs1D = 8;
        repeat (CMAX + 5) tick();
        chk("sat_hold", 32'(StallCnt), 32'(CMAX));
        idle();

        // random traffic
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            reset     = ($urandom_range(0, 99) == 0);
            Rs1D      = 5'($urandom_range(0, 3));
            Rs2D      = 5'($urandom_range(0, 3));
            Rs1E      = 5'($urandom_range(0, 3));
            Rs2E      = 5'($urandom_range(0, 3));
            RdE       = 5'($urandom_range(0, 3));
            RdM       = 5'($urandom_range(0, 3));
            RdW       = 5'($urandom_range(0, 3));
            MdD       = ($urandom_range(0, 3) == 0);
            LoadE     = ($urandom_range(0, 3) == 0);
            MdStartE  = ($urandom_range(0, 4) == 0);
            PCSrcE    = ($urandom_range(0, 5) == 0);
            RegWriteM = 1'($urandom);
            RegWriteW = 1'($urandom);
            MdDone    = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller. It drives the stall, flush and clear controls that the IF/ID and ID/EX pipeline registers consume.
- It also generates the EX-stage forwarding selects.
- It tracks one outstanding multi-cycle (mul/div) operation in a one-entry scoreboard, so that younger dependent instructions are held in ID until the result is written.
- It keeps a saturating count of stall cycles for performance checks.

Parameters:
CNT_W, 16, width of the stall-cycle counter StallCnt

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
Rs1D  input  5  rs1 of instruction in ID
Rs2D  input  5  rs2 of instruction in ID
MdD  input  1  instruction in ID is a multi-cycle op
Rs1E  input  5  rs1 of instruction in EX
Rs2E  input  5  rs2 of instruction in EX
RdE  input  5  rd of instruction in EX
LoadE  input  1  instruction in EX is a load (ResultSrcE selects memory)
MdStartE  input  1  multi-cycle op in EX launches this cycle
PCSrcE  input  1  taken branch/jump resolved in EX
RdM  input  5  rd in MEM
RegWriteM  input  1  MEM writes register file
RdW  input  5  rd in WB
RegWriteW  input  1  WB writes register file
MdDone  input  1  multi-cycle unit writes its result this cycle (one-cycle pulse)
StallF  output  1  hold PC
StallD  output  1  hold IF/ID register
FlushD  output  1  clear IF/ID register
FlushE  output  1  clear input of ID/EX register
ForwardAE  output  2  EX operand A select: 00 RF, 01 WB result, 10 MEM ALU result
ForwardBE  output  2  EX operand B select, same encoding
MdBusy  output  1  scoreboard entry valid
StallCnt  output  CNT_W  saturating count of cycles with StallD=1

Behaviour:
State, all updated on the rising edge of clk:
- PendV: scoreboard valid bit.
- PendRd[4:0]: destination register of the outstanding op.
- StallCnt.

Reset:
- reset=1 at an edge sets PendV=0, PendRd=0 and StallCnt=0, with priority over all other updates.
- Reset applied mid-operation drops the outstanding entry; no completion is expected afterwards.
- Combinational outputs follow from the reset state and the inputs. With PendV=0 and all inputs 0, every output is 0.

Forwarding (combinational, same rule for B using Rs2E):
- ForwardAE=10 if RegWriteM and RdM!=0 and RdM==Rs1E.
- Otherwise ForwardAE=01 if RegWriteW and RdW!=0 and RdW==Rs1E.
- Otherwise ForwardAE=00.
- MEM has priority over WB.

Hazard terms (combinational):
- lwStall = LoadE and RdE!=0 and (RdE==Rs1D or RdE==Rs2D).
- mdBlk = PendV and not MdDone and PendRd!=0 and (PendRd==Rs1D or PendRd==Rs2D).
- mdStruct = MdD and (MdStartE or (PendV and not MdDone)). Only one outstanding op is allowed.
- MdDone releases the dependency in the same cycle: the RF write in that cycle is visible to ID through write-first register-file bypass.
- hz = lwStall or mdBlk or mdStruct.

Outputs:
- PCSrcE=1 overrides everything: StallF=0, StallD=0, FlushD=1, FlushE=1.
- PCSrcE=0: StallF=hz, StallD=hz, FlushD=0, FlushE=hz (a bubble is inserted into EX).
- MdBusy=PendV.

Scoreboard update, in priority order:
1. reset.
2. MdStartE and RdE!=0: PendV<=1, PendRd<=RdE. This also applies when MdDone is high in the same cycle (completion of the old op and launch of a new one); the new entry wins.
3. MdStartE with RdE==0: PendV<=0 if MdDone, otherwise unchanged.
4. MdDone: PendV<=0.
5. Otherwise hold.
- MdDone while PendV=0 is ignored.
- MdStartE is not affected by PCSrcE or FlushE, because the op in EX is older than the branch.

Counter:
- StallCnt increments when StallD=1.
- It saturates at all-ones: no wrap.

Test Plan:
- Load-use: LoadE=1, RdE=5, Rs1D=5 -> StallF=StallD=FlushE=1, FlushD=0, for exactly one cycle; StallCnt goes 0->1. Same case with RdE=0 -> no stall.
- Forward priority: RegWriteM=RegWriteW=1, RdM=RdW=Rs1E=7 -> ForwardAE=10. Set RegWriteM=0 -> ForwardAE=01. Set Rs1E=0 -> ForwardAE=00.
- MD dependency: MdStartE=1, RdE=9; next cycle Rs2D=9 -> MdBusy=1 and stall held each cycle. MdDone pulse on cycle 4 -> StallD=0 in that cycle, MdBusy=0 next cycle, StallCnt=3.
- Structural: PendV=1, MdD=1, MdDone=0 -> stall. Simultaneous MdDone=1 and MdStartE=1 (RdE=12) -> PendV stays 1, PendRd=12.
- Branch priority: lwStall active and PCSrcE=1 -> StallF=StallD=0, FlushD=FlushE=1, StallCnt unchanged.
- Reset mid-op: PendV=1, then reset=1 for one edge -> MdBusy=0, StallCnt=0. A subsequent MdDone has no effect. Also drive StallD=1 with StallCnt preloaded near all-ones via a long stall and check it holds at 2^CNT_W-1.
